// File: rtl/phase_stepper_nch.sv
// phase_stepper_nch
//
// Square-wave reference generator with NCH independent channels. Each
// channel toggles mod[i] every HALF_PERIOD+1 clock cycles. A debounced
// push-button press moves one channel's phase by shortening (left key) or
// lengthening (right key) a single half-period by a fine or coarse step.
// A signed, saturating accumulator per channel records the net applied
// steps.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   key_ctl    raw buttons, active-low: [0]=left (shorten), [1]=right (lengthen)
//   sw_ctl     step size select: 0=FINE_STEP, 1=COARSE_STEP
//   ch_sel     channel targeted by presses and shown on phase_ofs
//   sync_all   single-cycle pulse: realign all channels (accumulators kept)
//   mod        per-channel square waves
//   pend       per-channel flag: nudge latched, waiting for the next wrap
//   phase_ofs  signed net applied steps of channel ch_sel (registered)

module phase_stepper_nch #(
    parameter int NCH         = 2,
    parameter int CNT_W       = 16,
    parameter int HALF_PERIOD = 9999,
    parameter int FINE_STEP   = 1,
    parameter int COARSE_STEP = 50,
    parameter int ACC_W       = 16,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              key_ctl,
    input  logic                    sw_ctl,
    input  logic [CH_W-1:0]         ch_sel,
    input  logic                    sync_all,
    output logic [NCH-1:0]          mod,
    output logic [NCH-1:0]          pend,
    output logic signed [ACC_W-1:0] phase_ofs
);

    localparam logic [CNT_W-1:0] LIM_NOM = CNT_W'(HALF_PERIOD);
    localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));

    // Elaboration-time parameter sanity checks.
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("phase_stepper_nch: NCH must be in 1..8");
    end
    if (COARSE_STEP >= HALF_PERIOD) begin : g_bad_step
        $error("phase_stepper_nch: COARSE_STEP must be smaller than HALF_PERIOD");
    end
    if ((longint'(HALF_PERIOD) + longint'(COARSE_STEP)) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_width
        $error("phase_stepper_nch: HALF_PERIOD+COARSE_STEP does not fit in CNT_W");
    end

    // Saturating accumulator step: adds +step (up) or -step (down).
    function automatic logic signed [ACC_W-1:0] acc_step(
        input logic signed [ACC_W-1:0] a,
        input logic                    up,
        input logic                    big
    );
        longint d;
        longint s;
        d = big ? longint'(COARSE_STEP) : longint'(FINE_STEP);
        s = longint'(a) + (up ? d : -d);
        if (s > ACC_MAX) begin
            s = ACC_MAX;
        end else if (s < ACC_MIN) begin
            s = ACC_MIN;
        end
        return ACC_W'(s);
    endfunction

    // Key path: two sync flops (d, q) plus the previous q for edge detect.
    logic [1:0] key_d_q, key_d_d;
    logic [1:0] key_q_q, key_q_d;
    logic [1:0] key_prev_q, key_prev_d;
    logic [1:0] hold_q, hold_d;

    // Per-channel state.
    logic [CNT_W-1:0]        cnt_q    [NCH];
    logic [CNT_W-1:0]        cnt_d    [NCH];
    logic [CNT_W-1:0]        lim_q    [NCH];
    logic [CNT_W-1:0]        lim_d    [NCH];
    logic signed [ACC_W-1:0] acc_q    [NCH];
    logic signed [ACC_W-1:0] acc_d    [NCH];
    logic [NCH-1:0]          mod_q, mod_d;
    logic [NCH-1:0]          pend_q, pend_d;
    logic [NCH-1:0]          right_q, right_d;   // 1 = lengthen, 0 = shorten
    logic [NCH-1:0]          coarse_q, coarse_d; // step size latched with the press
    logic signed [ACC_W-1:0] phase_ofs_q, phase_ofs_d;

    // Combinational helpers.
    logic [1:0]              press_raw;
    logic                    take_left;
    logic                    take_right;
    logic                    sel_ok;
    logic                    press_any;
    logic signed [ACC_W-1:0] acc_sel;
    logic [NCH-1:0]          wrap;
    logic [NCH-1:0]          hit;
    logic [CNT_W-1:0]        step_amt [NCH];

    always_comb begin
        key_d_d    = key_ctl;
        key_q_d    = key_d_q;
        key_prev_d = key_q_q;

        // A falling edge at q is a press unless that key's hold flag is set.
        press_raw  = key_prev_q & ~key_q_q & ~hold_q;
        // Simultaneous presses: left wins, right is discarded.
        take_left  = press_raw[0];
        take_right = press_raw[1] & ~press_raw[0];

        // Hold is set by any detected edge (even a discarded right one) and
        // cleared only once q shows the key released.
        for (int k = 0; k < 2; k++) begin
            if (press_raw[k]) begin
                hold_d[k] = 1'b1;
            end else if (key_q_q[k]) begin
                hold_d[k] = 1'b0;
            end else begin
                hold_d[k] = hold_q[k];
            end
        end

        // Decode ch_sel without relying on a width-limited compare.
        sel_ok  = 1'b0;
        acc_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                sel_ok  = 1'b1;
                acc_sel = acc_q[i];
            end
        end
        phase_ofs_d = sel_ok ? acc_sel : '0;

        press_any = (take_left | take_right) & sel_ok & ~sync_all;

        mod_d    = mod_q;
        pend_d   = pend_q;
        right_d  = right_q;
        coarse_d = coarse_q;
        wrap     = '0;
        hit      = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]    = cnt_q[i];
            lim_d[i]    = lim_q[i];
            acc_d[i]    = acc_q[i];
            step_amt[i] = coarse_q[i] ? CNT_W'(COARSE_STEP) : CNT_W'(FINE_STEP);
            wrap[i]     = (cnt_q[i] == lim_q[i]);
            // A channel with a nudge already pending drops further presses.
            hit[i]      = press_any & (ch_sel == CH_W'(i)) & ~pend_q[i];

            if (sync_all) begin
                cnt_d[i]  = '0;
                mod_d[i]  = 1'b0;
                lim_d[i]  = LIM_NOM;
                pend_d[i] = 1'b0;
            end else begin
                if (wrap[i]) begin
                    cnt_d[i] = '0;
                    mod_d[i] = ~mod_q[i];
                    // lim only changes while cnt restarts at 0, so it can
                    // never fall below the running count.
                    if (pend_q[i]) begin
                        lim_d[i]  = right_q[i] ? (LIM_NOM + step_amt[i])
                                               : (LIM_NOM - step_amt[i]);
                        pend_d[i] = 1'b0;
                        acc_d[i]  = acc_step(acc_q[i], right_q[i], coarse_q[i]);
                    end else begin
                        lim_d[i] = LIM_NOM;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end

                // hit implies pend_q=0, so it never collides with the apply above.
                if (hit[i]) begin
                    pend_d[i]   = 1'b1;
                    right_d[i]  = take_right;
                    coarse_d[i] = sw_ctl;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_d_q     <= '0;
            key_q_q     <= '0;
            key_prev_q  <= '0;
            hold_q      <= '0;
            mod_q       <= '0;
            pend_q      <= '0;
            right_q     <= '0;
            coarse_q    <= '0;
            phase_ofs_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                lim_q[i] <= LIM_NOM;
                acc_q[i] <= '0;
            end
        end else begin
            key_d_q     <= key_d_d;
            key_q_q     <= key_q_d;
            key_prev_q  <= key_prev_d;
            hold_q      <= hold_d;
            mod_q       <= mod_d;
            pend_q      <= pend_d;
            right_q     <= right_d;
            coarse_q    <= coarse_d;
            phase_ofs_q <= phase_ofs_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                lim_q[i] <= lim_d[i];
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign mod       = mod_q;
    assign pend      = pend_q;
    assign phase_ofs = phase_ofs_q;

endmodule

// File: tb/tb_phase_stepper_nch.sv
// Testbench for phase_stepper_nch (NCH=2, HALF_PERIOD=9, FINE=1, COARSE=3, ACC_W=4).
// The reference model tracks, per channel, the cycle of the next toggle and
// any pending half-period delta; every change it predicts on mod, pend or
// phase_ofs is queued as a timestamped event and matched against the DUT's
// observed output changes by an independent monitor.

module tb_phase_stepper_nch;

    localparam int NCH    = 2;
    localparam int CNT_W  = 8;
    localparam int HP     = 9;
    localparam int FINE   = 1;
    localparam int COARSE = 3;
    localparam int ACC_W  = 4;
    localparam int CH_W   = 1;
    localparam int W      = 48;   // {cyc[31:0], kind[3:0], ch[3:0], val[7:0]}

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       key_ctl;
    logic             sw_ctl;
    logic [CH_W-1:0]  ch_sel;
    logic             sync_all;
    logic [NCH-1:0]   mod;
    logic [NCH-1:0]   pend;
    logic [ACC_W-1:0] phase_ofs;

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(negedge clk);
        cyc++;
    end

    phase_stepper_nch #(
        .NCH(NCH), .CNT_W(CNT_W), .HALF_PERIOD(HP), .FINE_STEP(FINE),
        .COARSE_STEP(COARSE), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .key_ctl(key_ctl), .sw_ctl(sw_ctl), .ch_sel(ch_sel),
        .sync_all(sync_all), .mod(mod), .pend(pend), .phase_ofs(phase_ofs)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    bit          m_mod    [NCH];
    bit          m_pend   [NCH];
    bit          m_right  [NCH];
    bit          m_coarse [NCH];
    int          m_acc    [NCH];
    int          m_next   [NCH];
    int          m_ofs = 0;
    logic [1:0]  h1 = '0, h2 = '0, h3 = '0;   // key samples of the last 3 edges

    function automatic logic [W-1:0] ev(input int c, input int kind, input int ch, input logic [7:0] v);
        return {32'(c), 4'(kind), 4'(ch), v};
    endfunction

    function automatic int sat(input int v);
        int lo, hi;
        lo = -(1 << (ACC_W - 1));
        hi = (1 << (ACC_W - 1)) - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_step();
        bit   om [NCH];
        bit   op [NCH];
        int   oo;
        bit   pl, pr;
        int   sel, d, len;
        logic [ACC_W-1:0] ob;
        for (int i = 0; i < NCH; i++) begin
            om[i] = m_mod[i];
            op[i] = m_pend[i];
        end
        oo  = m_ofs;
        sel = int'(ch_sel);
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_mod[i]  = 1'b0;
                m_pend[i] = 1'b0;
                m_acc[i]  = 0;
                m_next[i] = cyc + HP + 1;
            end
            m_ofs = 0;
            h1 = '0; h2 = '0; h3 = '0;
        end else begin
            // Press = key went high->low two samples ago (after the sync delay).
            pl = h3[0] && !h2[0];
            pr = h3[1] && !h2[1] && !pl;
            m_ofs = (sel < NCH) ? m_acc[sel] : 0;
            if (sync_all) begin
                for (int i = 0; i < NCH; i++) begin
                    m_mod[i]  = 1'b0;
                    m_pend[i] = 1'b0;
                    m_next[i] = cyc + HP + 1;
                end
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (cyc == m_next[i]) begin
                        m_mod[i] = !m_mod[i];
                        len = HP + 1;
                        if (m_pend[i]) begin
                            d = m_coarse[i] ? COARSE : FINE;
                            if (m_right[i]) begin
                                len      = len + d;
                                m_acc[i] = sat(m_acc[i] + d);
                            end else begin
                                len      = len - d;
                                m_acc[i] = sat(m_acc[i] - d);
                            end
                            m_pend[i] = 1'b0;
                        end
                        m_next[i] = cyc + len;
                    end
                end
                if ((pl || pr) && sel < NCH && !op[sel]) begin
                    m_pend[sel]   = 1'b1;
                    m_right[sel]  = pr;
                    m_coarse[sel] = sw_ctl;
                end
            end
            h3 = h2; h2 = h1; h1 = key_ctl;
        end
        for (int i = 0; i < NCH; i++)
            if (m_mod[i] != om[i]) exp_q.push_back(ev(cyc, 0, i, {7'b0, m_mod[i]}));
        for (int i = 0; i < NCH; i++)
            if (m_pend[i] != op[i]) exp_q.push_back(ev(cyc, 1, i, {7'b0, m_pend[i]}));
        if (m_ofs != oo) begin
            ob = ACC_W'(m_ofs);
            exp_q.push_back(ev(cyc, 2, 0, 8'(ob)));
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic sb_check(input logic [W-1:0] got);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got cyc=%0d kind=%0d ch=%0d val=%0h exp=none",
                     got[47:16], got[15:12], got[11:8], got[7:0]);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL sb_event got cyc=%0d kind=%0d ch=%0d val=%0h exp cyc=%0d kind=%0d ch=%0d val=%0h",
                         got[47:16], got[15:12], got[11:8], got[7:0],
                         e[47:16], e[15:12], e[11:8], e[7:0]);
            end
        end
    endtask

    initial begin
        logic [NCH-1:0]   pm;
        logic [NCH-1:0]   pp;
        logic [ACC_W-1:0] po;
        logic [W-1:0]     e;
        pm = '0; pp = '0; po = '0;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && int'(exp_q[0][47:16]) < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL sb_missing got=none exp cyc=%0d kind=%0d ch=%0d val=%0h",
                         e[47:16], e[15:12], e[11:8], e[7:0]);
            end
            for (int i = 0; i < NCH; i++)
                if (mod[i] !== pm[i]) sb_check(ev(cyc, 0, i, {7'b0, mod[i]}));
            for (int i = 0; i < NCH; i++)
                if (pend[i] !== pp[i]) sb_check(ev(cyc, 1, i, {7'b0, pend[i]}));
            if (phase_ofs !== po) sb_check(ev(cyc, 2, 0, 8'(phase_ofs)));
            pm = mod; pp = pend; po = phase_ofs;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input integer got, input integer exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic wait_pend_clear(input int ch);
        int k;
        k = 0;
        while (pend[ch] && k < 60) begin
            tick();
            k++;
        end
        checks++;
        if (pend[ch] !== 1'b0) begin
            errors++;
            $display("FAIL pend_timeout ch=%0d got=%b exp=0", ch, pend[ch]);
        end
    endtask

    task automatic pulse_sync();
        sync_all = 1'b1;
        tick();
        sync_all = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; key_ctl = 2'b11; sw_ctl = 1'b0; ch_sel = '0; sync_all = 1'b0;
        ticks(2);
        rst = 1'b0;
        chk("reset_mod", mod, 0);
        chk("reset_pend", pend, 0);
        chk("reset_ofs", $signed(phase_ofs), 0);
        ticks(25);

        // Left fine nudge on ch0, key held long: exactly one nudge.
        ch_sel = 0; sw_ctl = 1'b0; key_ctl = 2'b10;
        ticks(2);
        chk("pend_latency_early", pend[0], 0);
        tick();
        chk("pend_latency", pend[0], 1);
        ticks(37);
        key_ctl = 2'b11;
        ticks(10);
        chk("left_fine_ofs", $signed(phase_ofs), -1);

        // Coarse right nudges on ch1 until saturation.
        ch_sel = 1; sw_ctl = 1'b1;
        for (int n = 0; n < 4; n++) begin
            key_ctl = 2'b01;
            ticks(4);
            key_ctl = 2'b11;
            wait_pend_clear(1);
            ticks(2);
        end
        chk("right_sat_ofs", $signed(phase_ofs), 7);

        // Both keys at once: left only; held right gives nothing until released.
        ch_sel = 0; sw_ctl = 1'b0; key_ctl = 2'b00;
        ticks(4);
        key_ctl = 2'b01;
        wait_pend_clear(0);
        ticks(12);
        chk("no_repress_pend", pend[0], 0);
        chk("both_keys_ofs", $signed(phase_ofs), -2);
        key_ctl = 2'b11;
        ticks(3);
        key_ctl = 2'b01;
        ticks(4);
        key_ctl = 2'b11;
        wait_pend_clear(0);
        ticks(3);
        chk("right_after_release_ofs", $signed(phase_ofs), -1);

        // Second press while pending is dropped.
        pulse_sync();
        key_ctl = 2'b10;
        ticks(3);
        chk("pend_set", pend[0], 1);
        key_ctl = 2'b11;
        ticks(2);
        key_ctl = 2'b10;
        ticks(3);
        chk("pend_still", pend[0], 1);
        key_ctl = 2'b11;
        wait_pend_clear(0);
        ticks(3);
        chk("single_nudge_ofs", $signed(phase_ofs), -2);

        // sync_all discards a pending nudge and realigns both channels.
        pulse_sync();
        key_ctl = 2'b10;
        ticks(3);
        key_ctl = 2'b11;
        tick();
        chk("pend_before_sync", pend[0], 1);
        pulse_sync();
        chk("sync_pend", pend, 0);
        chk("sync_mod", mod, 0);
        ticks(12);
        chk("sync_ofs_kept", $signed(phase_ofs), -2);

        // Reset in the middle of a lengthened half-period.
        ch_sel = 1; sw_ctl = 1'b1;
        pulse_sync();
        key_ctl = 2'b01;
        ticks(3);
        key_ctl = 2'b11;
        wait_pend_clear(1);
        ticks(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_mod", mod, 0);
        chk("midrst_pend", pend, 0);
        chk("midrst_ofs", $signed(phase_ofs), 0);
        ticks(25);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) key_ctl[0] = ~key_ctl[0];
            if ($urandom_range(0, 7) == 0) key_ctl[1] = ~key_ctl[1];
            sw_ctl   = 1'($urandom_range(0, 1));
            ch_sel   = CH_W'($urandom_range(0, 1));
            sync_all = ($urandom_range(0, 99) == 0);
            rst      = ($urandom_range(0, 499) == 0);
            tick();
        end

        rst = 1'b0; sync_all = 1'b0; key_ctl = 2'b11;
        ticks(30);
        chk("sb_leftover", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
